// File: rtl/camera_cfg_sequencer.sv
// Camera configuration sequencer: walks a synchronous register-table ROM after
// power-up (or on a re-run request) and issues one SCCB write per table entry.
// Entry format {reg_addr[15:0], reg_data[7:0]}; reg_addr FFFF ends the table,
// FFFE inserts a reg_data millisecond delay.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   cfg_start       re-run request, honoured only when DONE or ERROR
//   rom_addr        table index; rom_data returns one cycle later
//   rom_data        table entry
//   sccb_start      one-cycle write request to the SCCB engine
//   sccb_address    register address for the current write
//   sccb_data       register data for the current write
//   sccb_ready      SCCB engine idle
//   busy            sequencer running (not DONE/ERROR)
//   done            table completed without error
//   error           ready-handshake timeout
//   wr_count        SCCB writes completed in the current run
module camera_cfg_sequencer #(
  parameter int unsigned CLK_FREQ      = 25000000,
  parameter int unsigned ROM_AW        = 8,
  parameter int unsigned PWRUP_CYCLES  = 25000000,
  parameter int unsigned READY_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  output logic              sccb_start,
  output logic [15:0]       sccb_address,
  output logic [7:0]        sccb_data,
  input  logic              sccb_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ROM_AW:0]   wr_count
);

  localparam int unsigned TICK_CYCLES = CLK_FREQ / 1000;
  localparam int unsigned WCW         = ROM_AW + 1;

  typedef enum logic [3:0] {
    PWRUP, FETCH, ROM_WAIT, DECODE, ISSUE,
    WAIT_LOW, WAIT_HIGH, DELAY, NEXT, DONE, ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       pwr_q, pwr_d;
  logic [31:0]       wd_q, wd_d;
  logic [31:0]       tick_q, tick_d;
  logic [7:0]        ms_q, ms_d;
  logic [ROM_AW-1:0] index_d;
  logic              start_d;
  logic [15:0]       addr_d;
  logic [7:0]        data_d;
  logic              busy_d, done_d, error_d;
  logic [ROM_AW:0]   wr_d;

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= PWRUP;
      pwr_q        <= '0;
      wd_q         <= '0;
      tick_q       <= '0;
      ms_q         <= '0;
      rom_addr     <= '0;
      sccb_start   <= 1'b0;
      sccb_address <= '0;
      sccb_data    <= '0;
      busy         <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      wr_count     <= '0;
    end else begin
      state_q      <= state_d;
      pwr_q        <= pwr_d;
      wd_q         <= wd_d;
      tick_q       <= tick_d;
      ms_q         <= ms_d;
      rom_addr     <= index_d;
      sccb_start   <= start_d;
      sccb_address <= addr_d;
      sccb_data    <= data_d;
      busy         <= busy_d;
      done         <= done_d;
      error        <= error_d;
      wr_count     <= wr_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    pwr_d   = pwr_q;
    wd_d    = wd_q;
    tick_d  = tick_q;
    ms_d    = ms_q;
    index_d = rom_addr;
    start_d = 1'b0;
    addr_d  = sccb_address;
    data_d  = sccb_data;
    wr_d    = wr_count;

    case (state_q)
      PWRUP: begin
        if (pwr_q >= 32'(PWRUP_CYCLES - 1)) begin
          pwr_d   = '0;
          state_d = FETCH;
        end else begin
          pwr_d = pwr_q + 32'd1;
        end
      end
      FETCH:    state_d = ROM_WAIT;
      ROM_WAIT: state_d = DECODE;
      DECODE: begin
        if (rom_data[23:8] == 16'hFFFF) begin
          state_d = DONE;
        end else if (rom_data[23:8] == 16'hFFFE) begin
          if (rom_data[7:0] == 8'd0) begin
            state_d = NEXT;
          end else begin
            ms_d    = rom_data[7:0];
            tick_d  = '0;
            state_d = DELAY;
          end
        end else begin
          addr_d  = rom_data[23:8];
          data_d  = rom_data[7:0];
          wd_d    = '0;
          state_d = ISSUE;
        end
      end
      // The three ready-wait states share one watchdog, cleared on each entry.
      ISSUE: begin
        if (sccb_ready) begin
          start_d = 1'b1;
          wd_d    = '0;
          state_d = WAIT_LOW;
        end else if (wd_q >= 32'(READY_TIMEOUT - 1)) begin
          state_d = ERROR;
        end else begin
          wd_d = wd_q + 32'd1;
        end
      end
      WAIT_LOW: begin
        if (!sccb_ready) begin
          wd_d    = '0;
          state_d = WAIT_HIGH;
        end else if (wd_q >= 32'(READY_TIMEOUT - 1)) begin
          state_d = ERROR;
        end else begin
          wd_d = wd_q + 32'd1;
        end
      end
      WAIT_HIGH: begin
        if (sccb_ready) begin
          wr_d    = wr_count + WCW'(1);
          state_d = NEXT;
        end else if (wd_q >= 32'(READY_TIMEOUT - 1)) begin
          state_d = ERROR;
        end else begin
          wd_d = wd_q + 32'd1;
        end
      end
      // One ms = TICK_CYCLES cycles; leave when the last ms expires.
      DELAY: begin
        if (tick_q >= 32'(TICK_CYCLES - 1)) begin
          tick_d = '0;
          if (ms_q <= 8'd1) begin
            ms_d    = '0;
            state_d = NEXT;
          end else begin
            ms_d = ms_q - 8'd1;
          end
        end else begin
          tick_d = tick_q + 32'd1;
        end
      end
      // Last table slot is an implicit end; the index never wraps.
      NEXT: begin
        if (rom_addr == {ROM_AW{1'b1}}) begin
          state_d = DONE;
        end else begin
          index_d = rom_addr + ROM_AW'(1);
          state_d = FETCH;
        end
      end
      DONE, ERROR: begin
        if (cfg_start) begin
          index_d = '0;
          wr_d    = '0;
          state_d = FETCH;
        end
      end
      default: state_d = PWRUP;
    endcase

    done_d  = (state_d == DONE);
    error_d = (state_d == ERROR);
    busy_d  = (state_d != DONE) && (state_d != ERROR);
  end

endmodule

// File: tb/tb_camera_cfg_sequencer.sv
// Directed bench for camera_cfg_sequencer with a registered table ROM and a
// model SCCB engine (ready low for 50 cycles after each accepted start, or
// forever while hang is set).
module tb_camera_cfg_sequencer;

  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_start;
  logic [AW-1:0] rom_addr;
  logic [23:0]   rom_data;
  logic          sccb_start;
  logic [15:0]   sccb_address;
  logic [7:0]    sccb_data;
  logic          sccb_ready = 1'b1;
  logic          busy, done, error;
  logic [AW:0]   wr_count;

  logic [23:0]   rom [0:3];
  logic          hang;
  int            eng_cnt = 0;

  int            cyc = 0;
  int            n_starts = 0;
  int            n_long = 0;
  logic          start_prev = 1'b0;
  int            st_cyc  [0:63];
  logic [15:0]   st_addr [0:63];
  logic [7:0]    st_data [0:63];

  int            n_assert = 0;
  int            n_fail = 0;

  camera_cfg_sequencer #(
    .CLK_FREQ(10000), .ROM_AW(AW), .PWRUP_CYCLES(100), .READY_TIMEOUT(200)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .sccb_start(sccb_start), .sccb_address(sccb_address), .sccb_data(sccb_data),
    .sccb_ready(sccb_ready), .busy(busy), .done(done), .error(error),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data one cycle after the address.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Model SCCB engine.
  always @(posedge clk) begin
    if (sccb_start && sccb_ready) begin
      sccb_ready <= 1'b0;
      eng_cnt    <= 49;
    end else if (!sccb_ready && eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
    end else if (!sccb_ready && !hang) begin
      sccb_ready <= 1'b1;
    end
  end

  // Cycle counter (edges since reset release) and start-pulse log.
  always @(posedge clk) begin
    cyc        <= rst_n ? cyc + 1 : 0;
    start_prev <= sccb_start;
    if (sccb_start && start_prev) n_long <= n_long + 1;
    if (sccb_start && n_starts < 64) begin
      st_cyc[n_starts]  <= cyc;
      st_addr[n_starts] <= sccb_address;
      st_data[n_starts] <= sccb_data;
      n_starts          <= n_starts + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic restart(output int r);
    @(negedge clk) cfg_start = 1'b1;
    @(posedge clk);
    #1 r = cyc;
    cfg_start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int max);
    int k;
    k = 0;
    while (!(done || error) && k < max) begin
      @(posedge clk); #1;
      k++;
    end
    check(tag, 32'(done || error), 32'd1);
  endtask

  task automatic wait_starts(input string tag, input int n, input int max);
    int k;
    k = 0;
    while (n_starts < n && k < max) begin
      @(posedge clk); #1;
      k++;
    end
    check(tag, 32'(n_starts >= n), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_start"}, 32'(sccb_start), 32'd0);
    check({tag, "_addr"}, 32'(sccb_address), 32'd0);
    check({tag, "_data"}, 32'(sccb_data), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_wr_count"}, 32'(wr_count), 32'd0);
  endtask

  task automatic load_basic();
    rom[0] = 24'h3A01_55; rom[1] = 24'h3A02_AA; rom[2] = 24'hFFFF_00; rom[3] = 24'h0000_00;
  endtask

  initial begin
    int r, n0, t_delay, t_zero;
    rst_n = 1'b0; cfg_start = 1'b0; hang = 1'b0;
    load_basic();

    // Reset and power-up sequence.
    repeat (3) @(posedge clk);
    #1 check_reset_vals("rst");
    @(negedge clk) rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1 check("pwrup_busy", 32'(busy), 32'd1);
    check("pwrup_no_start", 32'(n_starts), 32'd0);
    wait_end("t1_finish", 1000);
    check("t1_first_start", 32'(st_cyc[0]), 32'd104);
    check("t1_first_ge103", 32'(st_cyc[0] >= 103), 32'd1);
    check("t1_second_start", 32'(st_cyc[1]), 32'd161);
    check("t1_n_starts", 32'(n_starts), 32'd2);
    check("t1_w0", {8'h0, st_addr[0], st_data[0]}, 32'h3A01_55);
    check("t1_w1", {8'h0, st_addr[1], st_data[1]}, 32'h3A02_AA);
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_wr_count", 32'(wr_count), 32'd2);

    // 3 ms delay entry (10 cycles/ms) ahead of a write.
    rom[0] = 24'hFFFE_03; rom[1] = 24'h1234_56; rom[2] = 24'hFFFF_00; rom[3] = 24'hFFFF_00;
    n0 = n_starts;
    restart(r);
    wait_end("t2_finish", 500);
    t_delay = st_cyc[n0] - r;
    check("t2_delay_start", 32'(t_delay), 32'd38);
    check("t2_w", {8'h0, st_addr[n0], st_data[n0]}, 32'h1234_56);
    check("t2_wr_count", 32'(wr_count), 32'd1);

    // Zero-length delay entry.
    rom[0] = 24'hFFFE_00;
    n0 = n_starts;
    restart(r);
    wait_end("t2z_finish", 500);
    t_zero = st_cyc[n0] - r;
    check("t2z_start", 32'(t_zero), 32'd8);
    check("t2_delta_30pm2", 32'((t_delay - t_zero) >= 28 && (t_delay - t_zero) <= 32), 32'd1);

    // Engine never returns ready: watchdog timeout in WAIT_HIGH.
    load_basic();
    hang = 1'b1;
    n0 = n_starts;
    restart(r);
    repeat (205) @(posedge clk);
    #1 check("t3_err_before", 32'(error), 32'd0);
    @(posedge clk);
    #1 check("t3_err_at_200", 32'(error), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_done", 32'(done), 32'd0);
    check("t3_wr_count", 32'(wr_count), 32'd0);
    repeat (20) @(posedge clk);
    #1 check("t3_one_start", 32'(n_starts - n0), 32'd1);
    check("t3_err_held", 32'(error), 32'd1);

    // Recover from ERROR without a power-up wait.
    hang = 1'b0;
    repeat (3) @(posedge clk);
    n0 = n_starts;
    restart(r);
    check("t4_err_clear", 32'(error), 32'd0);
    check("t4_done_clear", 32'(done), 32'd0);
    check("t4_busy", 32'(busy), 32'd1);
    wait_end("t4_finish", 1000);
    check("t4_first_start", 32'(st_cyc[n0] - r), 32'd4);
    check("t4_n_starts", 32'(n_starts - n0), 32'd2);
    check("t4_w1", {8'h0, st_addr[n0+1], st_data[n0+1]}, 32'h3A02_AA);
    check("t4_done", 32'(done), 32'd1);
    check("t4_wr_count", 32'(wr_count), 32'd2);

    // Full table without terminator; cfg_start while busy is ignored.
    rom[0] = 24'h1111_01; rom[1] = 24'h2222_02; rom[2] = 24'h3333_03; rom[3] = 24'h4444_04;
    n0 = n_starts;
    restart(r);
    wait_starts("t5_first", n0 + 1, 100);
    restart(r);
    wait_end("t5_finish", 2000);
    check("t5_n_starts", 32'(n_starts - n0), 32'd4);
    check("t5_w0", {8'h0, st_addr[n0], st_data[n0]}, 32'h1111_01);
    check("t5_w3", {8'h0, st_addr[n0+3], st_data[n0+3]}, 32'h4444_04);
    check("t5_wr_count", 32'(wr_count), 32'd4);
    check("t5_rom_addr", 32'(rom_addr), 32'd3);
    repeat (10) @(posedge clk);
    #1 check("t5_no_wrap", 32'(rom_addr), 32'd3);
    check("t5_no_extra", 32'(n_starts - n0), 32'd4);
    check("t5_done", 32'(done), 32'd1);

    // Reset while in WAIT_LOW, then a fresh run with power-up.
    load_basic();
    n0 = n_starts;
    restart(r);
    repeat (4) @(posedge clk);
    #1 check("t6_in_wait_low", 32'(sccb_start), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 check_reset_vals("t6_rst");
    @(negedge clk) rst_n = 1'b1;
    n0 = n_starts;
    wait_end("t6_finish", 1000);
    check("t6_first_start", 32'(st_cyc[n0]), 32'd104);
    check("t6_wr_count", 32'(wr_count), 32'd2);
    check("start_single_cycle", 32'(n_long), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/camera_cfg_sequencer.md
Name: camera_cfg_sequencer

Overview:
- Walks a synchronous register-table ROM and feeds one SCCB write per entry into the SCCB write engine. Each entry carries a 16-bit camera register address and 8-bit data.
- Sits between the config ROM and the SCCB interface. It brings the camera up after reset and on software re-run request.
- Supports two in-table pseudo-entries: millisecond delay and end-of-table.
- Has a watchdog on the SCCB ready handshake.

Parameters:
- CLK_FREQ, 25000000: clk frequency in Hz; sets the 1 ms tick = CLK_FREQ/1000 cycles.
- ROM_AW, 8: ROM address width; table depth is 2^ROM_AW entries.
- PWRUP_CYCLES, 25000000: cycles to wait after reset before the first fetch (1 s at default clk).
- READY_TIMEOUT, 65535: maximum cycles allowed in either ready-wait state before ERROR.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- cfg_start  in  1  re-run request; sampled only in DONE or ERROR
- rom_addr  out  ROM_AW  table index; ROM returns rom_data one cycle after rom_addr changes
- rom_data  in  24  {reg_addr[23:8], reg_data[7:0]}
- sccb_start  out  1  one-cycle write request to the SCCB engine
- sccb_address  out  16  register address, held stable from the start pulse until ready returns high
- sccb_data  out  8  register data, same hold rule as sccb_address
- sccb_ready  in  1  SCCB engine idle; drops the cycle after it accepts start
- busy  out  1  high in every state except DONE and ERROR
- done  out  1  table completed without error; held until restart or reset
- error  out  1  ready timeout; held until restart or reset
- wr_count  out  ROM_AW+1  number of SCCB writes completed in the current run

Behaviour:
- Reset (rst_n=0 at a clk edge) gives: state=PWRUP, rom_addr=0, sccb_start=0, sccb_address=0, sccb_data=0, done=0, error=0, busy=1, wr_count=0, all counters cleared.
  - Reset mid-transaction aborts immediately. The SCCB engine is not waited on.
- PWRUP: count PWRUP_CYCLES cycles, then go to FETCH.
- FETCH: drive rom_addr = index, then go to ROM_WAIT.
- ROM_WAIT: one cycle for ROM latency, then go to DECODE.
- DECODE: register rom_data, then branch on reg_addr:
  - 16'hFFFF: end of table; go to DONE.
  - 16'hFFFE: delay entry; load ms_count = reg_data and go to DELAY. If reg_data = 0, skip straight to NEXT.
  - Any other value: load sccb_address and sccb_data, then go to ISSUE.
- ISSUE: wait for sccb_ready=1, then pulse sccb_start high for exactly 1 cycle and go to WAIT_LOW.
- WAIT_LOW: wait for sccb_ready=0, then go to WAIT_HIGH.
- WAIT_HIGH: wait for sccb_ready=1, then increment wr_count and go to NEXT.
- Watchdog: a shared counter, cleared on entry to each of ISSUE, WAIT_LOW and WAIT_HIGH, counts cycles spent in that state. Reaching READY_TIMEOUT goes to ERROR; sccb_start is never issued after the timeout.
- DELAY: a tick counter counts CLK_FREQ/1000 cycles per ms, decrementing ms_count. When ms_count reaches 0, go to NEXT.
  - Total delay = reg_data*CLK_FREQ/1000 cycles, within ±2 cycles.
- NEXT: if index = 2^ROM_AW-1, go to DONE (implicit end, no wrap). Otherwise index+1, then go to FETCH.
- DONE: done=1, busy=0.
- ERROR: error=1, busy=0, done=0.
- Restart: cfg_start=1 in DONE or ERROR clears done, error, index and wr_count, then goes to FETCH. PWRUP is skipped.
  - cfg_start is ignored in all other states, including PWRUP.
- sccb_start is 0 in every state except the single ISSUE exit cycle. sccb_address and sccb_data change only in DECODE.
- Steady-state overhead per write entry: 5 cycles plus the SCCB transaction time.

Test Plan:
- Reset, PWRUP_CYCLES=100, table {3A01_55, 3A02_AA, FFFF_00} with a model SCCB engine (ready low for 50 cycles after start) -> first sccb_start at cycle ≥103 after reset release; exactly 2 start pulses carrying addr/data 3A01/55 then 3A02/AA; done=1, wr_count=2, busy=0.
- CLK_FREQ=10000, table {FFFE_03, 1234_56, FFFF_00} -> sccb_start for 1234/56 occurs 30 cycles (±2) after the delay entry is decoded; a FFFE_00 entry inserts 0 delay cycles.
- Model engine holds ready=0 forever after the first start, READY_TIMEOUT=200 -> error=1 exactly 200 cycles after entering WAIT_HIGH; no further sccb_start; busy=0.
- In ERROR, fix the model and pulse cfg_start -> error clears the next cycle; table replays from index 0 with no PWRUP wait; done=1.
- ROM_AW=2, table with no FFFF entry (4 writes) -> 4 start pulses, rom_addr never wraps to 0, done=1, wr_count=4. Pulsing cfg_start while busy has no effect.
- Assert rst_n=0 while in WAIT_LOW -> next cycle all outputs at reset values; a new run begins with PWRUP.
